// File: rtl/poly_approximate_log2.sv
`default_nettype none
// poly_approximate_log2: log2(y) for y near 1.0 as a cubic in t = y - 1 (Horner form),
// sequenced over one shared FP multiplier and one shared FP adder. Rev 1.0.

module poly_approximate_log2_fmul #(
  parameter string PRECISION = "HALF",
  parameter int    BITS      = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_valid,
  output logic [BITS-1:0] o_c
);
  localparam int EW   = (PRECISION == "HALF") ? 5 : 8;
  localparam int MW   = BITS - 1 - EW;
  localparam int PW   = 2 * MW + 2;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic            w_s;
  logic [PW-1:0]   w_prod;
  logic [MW-1:0]   w_frac;
  int              w_e;
  logic [BITS-1:0] w_c;
  logic            r_valid;
  logic [BITS-1:0] r_c;

  // Truncating multiply; subnormals flush to signed zero.
  always_comb begin
    w_s    = i_a[BITS-1] ^ i_b[BITS-1];
    w_prod = PW'({1'b1, i_a[MW-1:0]}) * PW'({1'b1, i_b[MW-1:0]});
    w_e    = int'(i_a[BITS-2:MW]) + int'(i_b[BITS-2:MW]) - BIAS + int'(w_prod[PW-1]);
    w_frac = w_prod[PW-1] ? MW'(w_prod >> (MW + 1)) : MW'(w_prod >> MW);
    if (i_a[BITS-2:MW] == '0 || i_b[BITS-2:MW] == '0 || w_e <= 0)
      w_c = {w_s, {(BITS-1){1'b0}}};
    else if (w_e >= EMAX)
      w_c = {w_s, {EW{1'b1}}, {MW{1'b0}}};
    else
      w_c = {w_s, EW'(w_e), w_frac};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_c     <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_c <= w_c;
    end
  end

  assign o_valid = r_valid;
  assign o_c     = r_c;
endmodule

module poly_approximate_log2_fadd #(
  parameter string PRECISION = "HALF",
  parameter int    BITS      = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_valid,
  output logic [BITS-1:0] o_c
);
  localparam int EW   = (PRECISION == "HALF") ? 5 : 8;
  localparam int MW   = BITS - 1 - EW;
  localparam int SW   = MW + 5;
  localparam int EMAX = (1 << EW) - 1;

  logic            w_swap;
  logic [BITS-1:0] w_big, w_sml;
  int              w_eb, w_es, w_p, w_e;
  logic [SW-1:0]   w_mb, w_ms, w_sum;
  logic [MW-1:0]   w_frac;
  logic [BITS-1:0] w_c;
  logic            r_valid;
  logic [BITS-1:0] r_c;

  // Align the smaller magnitude onto the larger with 3 guard bits, then truncate.
  always_comb begin
    w_swap = (i_b[BITS-2:0] > i_a[BITS-2:0]);
    w_big  = w_swap ? i_b : i_a;
    w_sml  = w_swap ? i_a : i_b;
    w_eb   = int'(w_big[BITS-2:MW]);
    w_es   = int'(w_sml[BITS-2:MW]);
    w_mb   = {1'b0, (w_eb != 0), w_big[MW-1:0], 3'b000};
    w_ms   = {1'b0, (w_es != 0), w_sml[MW-1:0], 3'b000} >> (w_eb - w_es);
    w_sum  = (w_big[BITS-1] == w_sml[BITS-1]) ? w_mb + w_ms : w_mb - w_ms;
    w_p    = 0;
    for (int i = 0; i < SW; i++)
      if (w_sum[i]) w_p = i;
    w_frac = MW'((w_sum << (SW - 1 - w_p)) >> (SW - 1 - MW));
    w_e    = w_eb + w_p - (MW + 3);
    if (w_sum == '0 || w_e <= 0)
      w_c = '0;
    else if (w_e >= EMAX)
      w_c = {w_big[BITS-1], {EW{1'b1}}, {MW{1'b0}}};
    else
      w_c = {w_big[BITS-1], EW'(w_e), w_frac};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_c     <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_c <= w_c;
    end
  end

  assign o_valid = r_valid;
  assign o_c     = r_c;
endmodule

module poly_approximate_log2 #(
  parameter int    BITS      = 16,
  parameter string PRECISION = "HALF"
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] y,
  output logic            out_valid,
  output logic [BITS-1:0] x
);
  localparam bit IS_HALF = (PRECISION == "HALF");
  localparam logic [BITS-1:0] C_NEG_ONE = IS_HALF ? BITS'(32'h0000_BC00) : BITS'(32'hBF80_0000);
  localparam logic [BITS-1:0] C_C3      = IS_HALF ? BITS'(32'h0000_37B2) : BITS'(32'h3EF6_3843);
  localparam logic [BITS-1:0] C_C2      = IS_HALF ? BITS'(32'h0000_B9C5) : BITS'(32'hBF38_AA43);
  localparam logic [BITS-1:0] C_C1      = IS_HALF ? BITS'(32'h0000_3DC5) : BITS'(32'h3FB8_AA3B);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SUB  = 3'd1;
  localparam logic [2:0] S_M3   = 3'd2;
  localparam logic [2:0] S_A2   = 3'd3;
  localparam logic [2:0] S_M2   = 3'd4;
  localparam logic [2:0] S_A1   = 3'd5;
  localparam logic [2:0] S_M1   = 3'd6;

  logic [2:0]      r_state;
  logic            r_issue;
  logic            r_out_valid;
  logic [BITS-1:0] r_y, r_t, r_acc, r_x;
  logic            w_add_wait, w_mul_wait, w_add_iv, w_mul_iv, w_add_ov, w_mul_ov;
  logic [BITS-1:0] w_add_a, w_add_b, w_mul_a, w_mul_b, w_add_c, w_mul_c;

  // r_issue is set on every state entry, so each operation is launched for exactly one cycle.
  always_comb begin
    w_add_wait = (r_state == S_SUB) || (r_state == S_A2) || (r_state == S_A1);
    w_mul_wait = (r_state == S_M3) || (r_state == S_M2) || (r_state == S_M1);
    w_add_iv   = r_issue & w_add_wait;
    w_mul_iv   = r_issue & w_mul_wait;
    w_add_a    = r_acc;
    w_add_b    = C_NEG_ONE;
    w_mul_a    = r_acc;
    w_mul_b    = r_t;
    case (r_state)
      S_SUB:   w_add_a = r_y;
      S_A2:    w_add_b = C_C2;
      S_A1:    w_add_b = C_C1;
      S_M3: begin
        w_mul_a = r_t;
        w_mul_b = C_C3;
      end
      default: ;
    endcase
  end

  poly_approximate_log2_fadd #(.PRECISION(PRECISION), .BITS(BITS)) u_add (
    .clk(clk), .rstn(rstn), .i_valid(w_add_iv), .i_a(w_add_a), .i_b(w_add_b),
    .o_valid(w_add_ov), .o_c(w_add_c)
  );

  poly_approximate_log2_fmul #(.PRECISION(PRECISION), .BITS(BITS)) u_mul (
    .clk(clk), .rstn(rstn), .i_valid(w_mul_iv), .i_a(w_mul_a), .i_b(w_mul_b),
    .o_valid(w_mul_ov), .o_c(w_mul_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_issue     <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_t         <= '0;
      r_acc       <= '0;
      r_x         <= '0;
    end else begin
      r_issue     <= 1'b0;
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_y     <= y;
          r_state <= S_SUB;
          r_issue <= 1'b1;
        end
        S_SUB: if (w_add_ov) begin
          r_t     <= w_add_c;
          r_state <= S_M3;
          r_issue <= 1'b1;
        end
        S_M3: if (w_mul_ov) begin
          r_acc   <= w_mul_c;
          r_state <= S_A2;
          r_issue <= 1'b1;
        end
        S_A2: if (w_add_ov) begin
          r_acc   <= w_add_c;
          r_state <= S_M2;
          r_issue <= 1'b1;
        end
        S_M2: if (w_mul_ov) begin
          r_acc   <= w_mul_c;
          r_state <= S_A1;
          r_issue <= 1'b1;
        end
        S_A1: if (w_add_ov) begin
          r_acc   <= w_add_c;
          r_state <= S_M1;
          r_issue <= 1'b1;
        end
        S_M1: if (w_mul_ov) begin
          r_x         <= w_mul_c;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      assert (!w_add_ov || w_add_wait);
      assert (!w_mul_ov || w_mul_wait);
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign x         = r_x;
endmodule
`default_nettype wire

// File: tb/tb_poly_approximate_log2.sv
`default_nettype none
// tb_poly_approximate_log2: half and single builds side by side, checked against real-valued log2.
module tb_poly_approximate_log2;
  localparam int L_ADD   = 1;
  localparam int L_MUL   = 1;
  localparam int LAT     = 3 * (L_ADD + 1) + 3 * (L_MUL + 1);
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rstn, in_valid;
  logic [15:0] y_h, x_h;
  logic [31:0] y_s, x_s;
  logic        rdy_h, rdy_s, ov_h, ov_s;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  poly_approximate_log2 #(.BITS(16), .PRECISION("HALF")) dut_h (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_h),
    .y(y_h), .out_valid(ov_h), .x(x_h)
  );
  poly_approximate_log2 #(.BITS(32), .PRECISION("SINGLE")) dut_s (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_s),
    .y(y_s), .out_valid(ov_s), .x(x_s)
  );

  function automatic logic [31:0] r2f(input real r, input int ew, input int mw);
    int  e, m, bias;
    real v;
    bias = (1 << (ew - 1)) - 1;
    v = r;
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * real'(1 << mw) + 0.5);
    if (m == (1 << mw)) begin m = 0; e++; end
    return (32'(e + bias) << mw) | 32'(m);
  endfunction

  function automatic real f2r(input logic [31:0] b, input int ew, input int mw);
    int  e, m, bias;
    real v;
    bias = (1 << (ew - 1)) - 1;
    e = int'((b >> mw) & ((32'd1 << ew) - 32'd1));
    m = int'(b & ((32'd1 << mw) - 32'd1));
    if (e == 0) v = 0.0;
    else v = (1.0 + real'(m) / real'(1 << mw)) * (2.0 ** real'(e - bias));
    if (b[ew + mw]) v = -v;
    return v;
  endfunction

  task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(input string tag, input real yq, input real xo, input real tol);
    real xr, err;
    xr  = $ln(yq) / $ln(2.0);
    err = (xo > xr) ? xo - xr : xr - xo;
    n_checks++;
    assert ((err <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s y=%f observed=%f expected=%f tol=%f", tag, yq, xo, xr, tol);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] yh, input logic [31:0] ys, input real tol);
    chk_one({tag, "_half"}, f2r({16'h0, yh}, 5, 10), f2r({16'h0, x_h}, 5, 10), tol);
    chk_one({tag, "_single"}, f2r(ys, 8, 23), f2r(x_s, 8, 23), tol);
  endtask

  task automatic set_y(input real yr);
    logic [31:0] b;
    b   = r2f(yr, 5, 10);
    y_h = b[15:0];
    y_s = r2f(yr, 8, 23);
  endtask

  // Presents y for one rising edge; returns at the falling edge after the accept edge.
  task automatic start(input real yr, output logic [15:0] yh, output logic [31:0] ys);
    @(negedge clk);
    set_y(yr);
    yh = y_h;
    ys = y_s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!(ov_h || ov_s) && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input real yr, input real tol);
    logic [15:0] yh;
    logic [31:0] ys;
    int          lat;
    start(yr, yh, ys);
    wait_out(lat);
    chk_bits({tag, "_lat"}, lat, LAT);
    chk_result(tag, yh, ys, tol);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] yh0, yh1;
    logic [31:0] ys0, ys1;
    int          lat, cnt;
    real         yr;

    rstn = 1'b0; in_valid = 1'b0; y_h = '0; y_s = '0;
    repeat (3) @(negedge clk);
    chk_bits("rst_ready_h", rdy_h, 1);
    chk_bits("rst_ready_s", rdy_s, 1);
    chk_bits("rst_ov_h", ov_h, 0);
    chk_bits("rst_ov_s", ov_s, 0);
    chk_bits("rst_x_h", x_h, 0);
    chk_bits("rst_x_s", x_s, 0);
    rstn = 1'b1;
    @(negedge clk);

    // y = 1.0 yields exactly +0.0 with a single out_valid pulse
    start(1.0, yh0, ys0);
    chk_bits("one_y_h", yh0, 32'h3C00);
    wait_out(lat);
    chk_bits("one_lat", lat, LAT);
    chk_bits("one_ov_h", ov_h, 1);
    chk_bits("one_ov_s", ov_s, 1);
    chk_bits("one_x_h", x_h, 0);
    chk_bits("one_x_s", x_s, 0);
    @(negedge clk);
    chk_bits("one_pulse_h", ov_h, 0);
    chk_bits("one_pulse_s", ov_s, 0);
    chk_bits("one_hold_h", x_h, 0);

    run_check("y125", 1.25, 0.01);
    run_check("y075", 0.75, 0.01);

    for (int i = 0; i < 256; i++)
      run_check("sweep", 0.70711 + real'(i) * (1.41421 - 0.70711) / 255.0, 0.011);

    for (int i = 0; i < 40; i++) begin
      yr = 0.7072 + (1.4141 - 0.7072) * real'($urandom_range(0, 10000)) / 10000.0;
      run_check("rand", yr, 0.011);
    end

    // in_valid held high while busy: ignored, y latch untouched
    start(1.25, yh0, ys0);
    lat = 0; cnt = 0;
    while (!(ov_h || ov_s) && lat < TIMEOUT) begin
      if (rdy_h || rdy_s) cnt++;
      set_y(0.75);
      in_valid = 1'b1;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk_bits("busy_lat", lat, LAT);
    chk_bits("busy_ready_high", cnt, 0);
    chk_result("busy", yh0, ys0, 0.011);
    cnt = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (ov_h || ov_s) cnt++;
    end
    chk_bits("busy_extra_results", cnt, 0);

    // reset while the M2 multiply is in flight
    start(0.75, yh0, ys0);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_bits("abort_ready_h", rdy_h, 1);
    chk_bits("abort_ov_h", ov_h, 0);
    chk_bits("abort_x_h", x_h, 0);
    chk_bits("abort_x_s", x_s, 0);
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (ov_h || ov_s) cnt++;
    end
    chk_bits("abort_no_result", cnt, 0);
    chk_bits("abort_ready_s", rdy_s, 1);
    chk_bits("abort_x_after", x_h, 0);
    run_check("post_rst", 1.25, 0.01);

    // back-to-back: next y presented in the out_valid cycle
    start(1.25, yh0, ys0);
    wait_out(lat);
    chk_bits("b2b_lat1", lat, LAT);
    chk_result("b2b_first", yh0, ys0, 0.01);
    chk_bits("b2b_ready", rdy_h, 1);
    set_y(0.75);
    yh1 = y_h;
    ys1 = y_s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk_bits("b2b_lat2", lat, LAT);
    chk_result("b2b_second", yh1, ys1, 0.01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
